// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 binary-coded-modulation sequencer.
package hub75_pkg;

    localparam int unsigned LsbLenW = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StShift  = 3'd1,
        StWait   = 3'd2,
        StBlank  = 3'd3,
        StLatch  = 3'd4,
        StPost   = 3'd5,
        StOn     = 3'd6,
        StRowEnd = 3'd7
    } bcm_state_e;

    // On-timer must hold the longest on-time: 255 << (bitdepth-1).
    function automatic int unsigned on_time_width(input int unsigned bitdepth);
        return LsbLenW + bitdepth - 1;
    endfunction

endpackage

// File: rtl/hub75_bcm_ctrl_if.sv
// Row-request, shifter handshake and PHY-side signals of the BCM sequencer.
interface hub75_bcm_ctrl_if #(
    parameter int unsigned LOG_N_ROWS = 5,
    parameter int unsigned LOG_BD     = 3
);
    logic                  row_go;
    logic [LOG_N_ROWS-1:0] row_addr;
    logic                  row_rdy;
    logic                  shift_go;
    logic [LOG_BD-1:0]     shift_plane;
    logic                  shift_rdy;
    logic                  phy_addr_inc;
    logic                  phy_addr_rst;
    logic [LOG_N_ROWS-1:0] phy_addr;
    logic                  phy_le;
    logic                  phy_blank;

    modport master (
        input  row_go, row_addr, shift_rdy,
        output row_rdy, shift_go, shift_plane,
        output phy_addr_inc, phy_addr_rst, phy_addr, phy_le, phy_blank
    );

    modport slave (
        output row_go, row_addr, shift_rdy,
        input  row_rdy, shift_go, shift_plane,
        input  phy_addr_inc, phy_addr_rst, phy_addr, phy_le, phy_blank
    );

endinterface

// File: rtl/hub75_bcm_timer.sv
// On-time down-counter: loads max(lsb_len,1) << plane and flags the last and expired cycles.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int unsigned BITDEPTH = 8,
    parameter int unsigned LOG_BD   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [LsbLenW-1:0] lsb_len_i,
    input  logic [LOG_BD-1:0]  plane_i,
    output logic               last_o,
    output logic               expired_o
);

    localparam int unsigned TW = on_time_width(BITDEPTH);

    logic [TW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      load_val;
    logic [LsbLenW-1:0] lsb_eff;
    logic               expired_q;

    always_comb begin
        lsb_eff  = (lsb_len_i == '0) ? LsbLenW'(1) : lsb_len_i;
        load_val = TW'(lsb_eff) << plane_i;
        cnt_d    = cnt_q;
        if (load_i) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Expired is registered so it can drive the panel blank line directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign last_o    = (cnt_q <= TW'(1));
    assign expired_o = expired_q;

endmodule

// File: rtl/hub75_bcm_ctrl.sv
// BCM row sequencer: shifts plane p+1 while plane p is displayed, then latches and unblanks it.
module hub75_bcm_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned N_ROWS     = 32,
    parameter int unsigned LOG_N_ROWS = 5,
    parameter int unsigned BITDEPTH   = 8,
    parameter int unsigned LOG_BD     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LsbLenW-1:0] ctrl_lsb_len,
    hub75_bcm_ctrl_if.master   bus
);

    localparam logic [LOG_BD-1:0]     PlaneLast = LOG_BD'(BITDEPTH - 1);
    localparam logic [LOG_N_ROWS-1:0] RowLast   = LOG_N_ROWS'(N_ROWS - 1);

    bcm_state_e            state_q, state_d;
    logic [LOG_N_ROWS-1:0] row_q, row_d;
    logic [LOG_N_ROWS-1:0] addr_q, addr_d;
    logic [LOG_N_ROWS-1:0] addr_succ;
    logic [LOG_BD-1:0]     plane_q, plane_d;
    logic                  shift_seen_q, shift_seen_d;
    logic                  le_q, le_d;
    logic                  addr_inc_q, addr_inc_d;
    logic                  addr_rst_q, addr_rst_d;
    logic                  tmr_load;
    logic                  tmr_last;
    logic                  tmr_expired;

    hub75_bcm_timer #(
        .BITDEPTH (BITDEPTH),
        .LOG_BD   (LOG_BD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .lsb_len_i (ctrl_lsb_len),
        .plane_i   (plane_q),
        .last_o    (tmr_last),
        .expired_o (tmr_expired)
    );

    assign addr_succ = (addr_q == RowLast) ? '0 : addr_q + LOG_N_ROWS'(1);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        shift_seen_d = shift_seen_q;
        addr_d       = addr_q;
        le_d         = 1'b0;
        addr_inc_d   = 1'b0;
        addr_rst_d   = 1'b0;
        tmr_load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.row_go) begin
                    row_d        = bus.row_addr;
                    plane_d      = '0;
                    shift_seen_d = 1'b0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                shift_seen_d = bus.shift_rdy;
                state_d      = StWait;
            end
            StWait: begin
                // Leave on the last lit cycle so the blank gap is exactly BLANK/LATCH/POST.
                if ((shift_seen_q || bus.shift_rdy) && tmr_last) begin
                    state_d = StBlank;
                end else if (bus.shift_rdy) begin
                    shift_seen_d = 1'b1;
                end
            end
            StBlank: begin
                le_d       = 1'b1;
                addr_d     = row_q;
                addr_inc_d = (row_q == addr_succ) && (row_q != addr_q);
                addr_rst_d = (row_q == '0) && (addr_q != '0);
                state_d    = StLatch;
            end
            StLatch: begin
                state_d = StPost;
            end
            StPost: begin
                tmr_load = 1'b1;
                state_d  = StOn;
            end
            StOn: begin
                if (plane_q != PlaneLast) begin
                    plane_d      = plane_q + LOG_BD'(1);
                    shift_seen_d = 1'b0;
                    state_d      = StShift;
                end else begin
                    state_d = StRowEnd;
                end
            end
            StRowEnd: begin
                if (bus.row_go) begin
                    row_d        = bus.row_addr;
                    plane_d      = '0;
                    shift_seen_d = 1'b0;
                    state_d      = StShift;
                end else if (tmr_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            row_q        <= '0;
            addr_q       <= '0;
            plane_q      <= '0;
            shift_seen_q <= 1'b0;
            le_q         <= 1'b0;
            addr_inc_q   <= 1'b0;
            addr_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            plane_q      <= plane_d;
            shift_seen_q <= shift_seen_d;
            le_q         <= le_d;
            addr_inc_q   <= addr_inc_d;
            addr_rst_q   <= addr_rst_d;
        end
    end

    assign bus.row_rdy      = (state_q == StIdle) || (state_q == StRowEnd);
    assign bus.shift_go     = (state_q == StShift);
    assign bus.shift_plane  = plane_q;
    assign bus.phy_le       = le_q;
    assign bus.phy_addr     = addr_q;
    assign bus.phy_addr_inc = addr_inc_q;
    assign bus.phy_addr_rst = addr_rst_q;
    assign bus.phy_blank    = tmr_expired;

endmodule
